// File: rtl/key_entry_ctrl_if.sv
// Keypad / ALU / display signal bundle for key_entry_ctrl.
// The master drives keypad and ALU responses; the slave is the controller.
interface key_entry_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  key_ready;
    logic [4*DIGITS-1:0]   op_a;
    logic [4*DIGITS-1:0]   op_b;
    logic [1:0]            op_code;
    logic                  calc_req;
    logic                  calc_ack;
    logic [4*DIGITS-1:0]   result_bcd;
    logic                  result_err;
    logic [4*DIGITS-1:0]   disp_value;
    logic                  err;
    logic [1:0]            state;

    modport master (
        output key_valid, key_code, calc_ack, result_bcd, result_err,
        input  key_ready, op_a, op_b, op_code, calc_req, disp_value, err, state
    );

    modport slave (
        input  key_valid, key_code, calc_ack, result_bcd, result_err,
        output key_ready, op_a, op_b, op_code, calc_req, disp_value, err, state
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Calculator operand-entry sequencer: builds two BCD operands and an operator from
// keypad codes, then hands them to the ALU over a req/ack handshake with timeout.
module key_entry_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input logic             clk,
    input logic             rst,
    key_entry_ctrl_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);
    localparam int unsigned TmrW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StEnterA     = 2'd0,
        StEnterB     = 2'd1,
        StRequest    = 2'd2,
        StShowResult = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic [1:0]        op_code_q, op_code_d;
    logic [CntW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              req_q, req_d, err_q, err_d;

    logic              accept, is_digit, is_op, is_eq, is_clr;
    logic [3:0]        op_sel;
    logic [W-1:0]      digit_w;

    assign accept   = bus.key_valid && (state_q != StRequest);
    assign is_digit = (bus.key_code <= 4'd9);
    assign is_op    = (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    assign is_eq    = (bus.key_code == 4'd14);
    assign is_clr   = (bus.key_code == 4'd15);
    assign op_sel   = bus.key_code - 4'd10;
    assign digit_w  = {{(W-4){1'b0}}, bus.key_code};

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        result_d  = result_q;
        op_code_d = op_code_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        timer_d   = timer_q;
        req_d     = req_q;
        err_d     = err_q;

        if (state_q == StRequest) begin
            // Ack takes priority over a simultaneous timeout.
            if (bus.calc_ack) begin
                req_d    = 1'b0;
                result_d = bus.result_bcd;
                err_d    = bus.result_err;
                state_d  = StShowResult;
            end else if (timer_q == TmrW'(ACK_TIMEOUT - 1)) begin
                req_d    = 1'b0;
                result_d = '0;
                err_d    = 1'b1;
                state_d  = StShowResult;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else if (accept) begin
            err_d = 1'b0;
            if (is_clr) begin
                state_d   = StEnterA;
                op_a_d    = '0;
                op_b_d    = '0;
                result_d  = '0;
                op_code_d = '0;
                cnt_a_d   = '0;
                cnt_b_d   = '0;
                timer_d   = '0;
                req_d     = 1'b0;
            end else begin
                unique case (state_q)
                    StEnterA: begin
                        if (is_digit && cnt_a_q != CntW'(DIGITS)) begin
                            op_a_d  = {op_a_q[W-5:0], bus.key_code};
                            cnt_a_d = cnt_a_q + 1'b1;
                        end else if (is_op) begin
                            op_code_d = op_sel[1:0];
                            op_b_d    = '0;
                            cnt_b_d   = '0;
                            state_d   = StEnterB;
                        end
                    end
                    StEnterB: begin
                        if (is_digit && cnt_b_q != CntW'(DIGITS)) begin
                            op_b_d  = {op_b_q[W-5:0], bus.key_code};
                            cnt_b_d = cnt_b_q + 1'b1;
                        end else if (is_op) begin
                            op_code_d = op_sel[1:0];
                        end else if (is_eq && cnt_b_q != '0) begin
                            req_d   = 1'b1;
                            timer_d = '0;
                            state_d = StRequest;
                        end
                    end
                    StShowResult: begin
                        if (is_digit) begin
                            op_a_d  = digit_w;
                            cnt_a_d = CntW'(1);
                            op_b_d  = '0;
                            state_d = StEnterA;
                        end else if (is_op) begin
                            if (err_q) begin
                                err_d = 1'b1;
                            end else begin
                                // Chain: previous result becomes a locked operand A.
                                op_a_d    = result_q;
                                cnt_a_d   = CntW'(DIGITS);
                                op_code_d = op_sel[1:0];
                                op_b_d    = '0;
                                cnt_b_d   = '0;
                                state_d   = StEnterB;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEnterA;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            op_code_q <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            result_q  <= result_d;
            op_code_q <= op_code_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            timer_q   <= timer_d;
            req_q     <= req_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bus.disp_value = op_a_q;
        unique case (state_q)
            StEnterA:     bus.disp_value = op_a_q;
            StEnterB:     bus.disp_value = (cnt_b_q != '0) ? op_b_q : op_a_q;
            StRequest:    bus.disp_value = op_b_q;
            StShowResult: bus.disp_value = result_q;
            default:      bus.disp_value = op_a_q;
        endcase
    end

    assign bus.key_ready = (state_q != StRequest);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.op_code   = op_code_q;
    assign bus.calc_req  = req_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios then random keys/acks, all checked
// against a decimal-level reference model of the entry rules.
module tb_key_entry_ctrl;
    localparam int unsigned Digits     = 4;
    localparam int unsigned AckTimeout = 16;
    localparam int unsigned W          = 4 * Digits;

    logic clk = 1'b0;
    logic rst;

    key_entry_ctrl_if #(.DIGITS(Digits)) bus ();

    key_entry_ctrl #(
        .DIGITS      (Digits),
        .ACK_TIMEOUT (AckTimeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: operands held as decimal integers.
    int m_state, m_a, m_b, m_cnt_a, m_cnt_b, m_opc, m_disp, m_timer;
    bit m_err;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < Digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_disp();
        case (m_state)
            0:       return m_a;
            1:       return (m_cnt_b > 0) ? m_b : m_a;
            2:       return m_b;
            default: return m_disp;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_cnt_a = 0; m_cnt_b = 0;
        m_opc = 0; m_disp = 0; m_timer = 0; m_err = 0;
    endtask

    task automatic model_update(input bit kv, input int kc, input bit ack, input int res,
                                input bit rerr, input bit r);
        bit keep_err;
        if (r) begin
            model_reset();
        end else if (m_state == 2) begin
            if (ack) begin
                m_disp = res; m_err = rerr; m_state = 3;
            end else if (m_timer == AckTimeout - 1) begin
                m_disp = 0; m_err = 1; m_state = 3;
            end else begin
                m_timer++;
            end
        end else if (kv) begin
            keep_err = 0;
            if (kc == 15) begin
                model_reset();
            end else if (m_state == 0) begin
                if (kc <= 9 && m_cnt_a < Digits) begin
                    m_a = m_a * 10 + kc; m_cnt_a++;
                end else if (kc >= 10 && kc <= 13) begin
                    m_opc = kc - 10; m_b = 0; m_cnt_b = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (kc <= 9 && m_cnt_b < Digits) begin
                    m_b = m_b * 10 + kc; m_cnt_b++;
                end else if (kc >= 10 && kc <= 13) begin
                    m_opc = kc - 10;
                end else if (kc == 14 && m_cnt_b > 0) begin
                    m_timer = 0; m_state = 2;
                end
            end else begin
                if (kc <= 9) begin
                    m_a = kc; m_cnt_a = 1; m_b = 0; m_state = 0;
                end else if (kc >= 10 && kc <= 13) begin
                    if (m_err) begin
                        keep_err = 1;
                    end else begin
                        m_a = m_disp; m_cnt_a = Digits; m_opc = kc - 10;
                        m_b = 0; m_cnt_b = 0; m_state = 1;
                    end
                end
            end
            if (!keep_err) m_err = 0;
        end
    endtask

    task automatic step(input bit kv, input int kc, input bit ack, input int res,
                        input bit rerr, input bit r);
        @(negedge clk);
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        bus.calc_ack   = ack;
        bus.result_bcd = to_bcd(res);
        bus.result_err = rerr;
        rst            = r;
        #1;
        check("key_ready", W'(bus.key_ready), W'(m_state != 2));
        model_update(kv, kc, ack, res, rerr, r);
        @(posedge clk);
        #1;
        check("state", W'(bus.state), W'(m_state));
        check("op_a", bus.op_a, to_bcd(m_a));
        check("op_b", bus.op_b, to_bcd(m_b));
        check("op_code", W'(bus.op_code), W'(m_opc));
        check("calc_req", W'(bus.calc_req), W'(m_state == 2));
        check("err", W'(bus.err), W'(m_err));
        check("disp_value", bus.disp_value, to_bcd(exp_disp()));
        bus.key_valid = 1'b0;
        bus.calc_ack  = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic key(input int kc);
        step(1'b1, kc, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int kc;
        bus.key_valid  = 1'b0;
        bus.key_code   = '0;
        bus.calc_ack   = 1'b0;
        bus.result_bcd = '0;
        bus.result_err = 1'b0;
        rst            = 1'b1;
        model_reset();

        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        check("rst_disp", bus.disp_value, 16'h0000);
        check("rst_state", W'(bus.state), W'(0));

        // Basic add with ack after a short delay.
        key(1); key(2); key(10); key(3); key(14);
        check("t1_req", W'(bus.calc_req), W'(1));
        idle(); idle();
        step(1'b0, 0, 1'b1, 15, 1'b0, 1'b0);
        check("t1_op_a", bus.op_a, 16'h0012);
        check("t1_op_b", bus.op_b, 16'h0003);
        check("t1_disp", bus.disp_value, 16'h0015);
        check("t1_state", W'(bus.state), W'(3));

        // Chain from result, then keys during REQUEST, then reset mid-request.
        key(12); key(2); key(14);
        check("t5_op_a", bus.op_a, 16'h0015);
        check("t5_op_code", W'(bus.op_code), W'(2));
        check("t5_op_b", bus.op_b, 16'h0002);
        key(5);
        check("t6_drop_op_b", bus.op_b, 16'h0002);
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b1);
        check("t6_rst_state", W'(bus.state), W'(0));
        check("t6_rst_op_a", bus.op_a, 16'h0000);

        // Fifth digit dropped.
        key(9); key(8); key(7); key(6); key(5);
        check("t2_op_a", bus.op_a, 16'h9876);

        // '#' before any B digit, last operator wins, then timeout.
        key(10); key(14);
        check("t3_no_req", W'(bus.state), W'(1));
        key(11); key(4); key(14);
        check("t3_op_code", W'(bus.op_code), W'(1));
        for (int i = 0; i < AckTimeout - 1; i++) idle();
        check("t4_req_held", W'(bus.calc_req), W'(1));
        idle();
        check("t4_req_fall", W'(bus.calc_req), W'(0));
        check("t4_err", W'(bus.err), W'(1));
        check("t4_disp", bus.disp_value, 16'h0000);
        key(10);
        check("t4_op_ignored", W'(bus.state), W'(3));
        key(15);

        // Random keys, acks and occasional resets.
        for (int n = 0; n < 600; n++) begin
            kc = $urandom_range(0, 19);
            if (kc > 15) kc = $urandom_range(0, 9);
            if (kc == 15 && $urandom_range(0, 2) != 0) kc = 14;
            step($urandom_range(0, 1) == 1, kc,
                 (m_state == 2) && ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 9999), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
